// File: rtl/mcpu_core_issue_ctl_if.sv
// rtl/mcpu_core_issue_ctl_if.sv - decode/scoreboard/downstream bundle for the issue controller
interface mcpu_core_issue_ctl_if;
  logic [31:0] sb2d_reg_scoreboard;
  logic [2:0]  sb2d_pred_scoreboard;
  logic        d2ic_valid;
  logic [31:0] d2ic_rs_mask;
  logic [31:0] d2ic_rd_mask;
  logic [2:0]  d2ic_pred_mask;
  logic        d2ic_flush;
  logic        pc2ic_ready;
  logic        ic_cnt_clr;
  logic        d2pc_progress;
  logic        ic2d_stall;
  logic [1:0]  ic_state;
  logic [15:0] ic_stall_cnt;
  logic        ic_wdog_err;

  modport master (
    output sb2d_reg_scoreboard, sb2d_pred_scoreboard, d2ic_valid, d2ic_rs_mask,
           d2ic_rd_mask, d2ic_pred_mask, d2ic_flush, pc2ic_ready, ic_cnt_clr,
    input  d2pc_progress, ic2d_stall, ic_state, ic_stall_cnt, ic_wdog_err
  );

  modport slave (
    input  sb2d_reg_scoreboard, sb2d_pred_scoreboard, d2ic_valid, d2ic_rs_mask,
           d2ic_rd_mask, d2ic_pred_mask, d2ic_flush, pc2ic_ready, ic_cnt_clr,
    output d2pc_progress, ic2d_stall, ic_state, ic_stall_cnt, ic_wdog_err
  );
endinterface

// File: rtl/mcpu_core_issue_ctl.sv
// rtl/mcpu_core_issue_ctl.sv - packet issue control: hazard stall, flush blocking, stall stats
// Optional stall watchdog is built only when MCPU_ISSUE_WATCHDOG_EN is defined.
module mcpu_core_issue_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT   = 1023
) (
  input logic                   clkrst_core_clk,
  input logic                   clkrst_core_rst,
  mcpu_core_issue_ctl_if.slave  ic
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] stall_cnt_q;
  logic        hazard;
  logic        progress;
  logic        stall_inc;

  // r0 is hardwired zero, so a pending write to it never creates a hazard
  always_comb begin
    hazard = (|(ic.d2ic_rs_mask & ic.sb2d_reg_scoreboard & 32'hFFFF_FFFE)) |
             (|(ic.d2ic_rd_mask & ic.sb2d_reg_scoreboard & 32'hFFFF_FFFE)) |
             (|(ic.d2ic_pred_mask & ic.sb2d_pred_scoreboard));
  end

  assign progress  = ic.d2ic_valid & ~hazard & ic.pc2ic_ready & ~ic.d2ic_flush &
                     (state_q != ST_FLUSH);
  assign stall_inc = ic.d2ic_valid & hazard & ~ic.d2ic_flush & (state_q != ST_FLUSH);

  assign ic.d2pc_progress = progress;
  assign ic.ic2d_stall    = ic.d2ic_valid & ~progress;
  assign ic.ic_state      = state_q;
  assign ic.ic_stall_cnt  = stall_cnt_q;

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (ic.d2ic_flush) begin
      state_d = ST_FLUSH;
      fcnt_d  = FLUSH_LOAD;
    end else if (state_q == ST_FLUSH) begin
      if (fcnt_q == 4'd0) begin
        state_d = ST_IDLE;
      end else begin
        fcnt_d = fcnt_q - 4'd1;
      end
    end else if (progress) begin
      state_d = ST_ISSUE;
    end else if (ic.d2ic_valid) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Only scoreboard hazards are counted; backpressure from downstream is not
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      stall_cnt_q <= 16'd0;
    end else if (ic.ic_cnt_clr) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

`ifdef MCPU_ISSUE_WATCHDOG_EN
  logic [15:0] wdog_cnt_q;
  logic        wdog_err_q;

  // Error is raised on the edge that closes the WDOG_LIMIT-th consecutive STALL cycle
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      wdog_cnt_q <= 16'd0;
      wdog_err_q <= 1'b0;
    end else if (state_q == ST_STALL) begin
      if (wdog_cnt_q != 16'hFFFF) begin
        wdog_cnt_q <= wdog_cnt_q + 16'd1;
      end
      if (({1'b0, wdog_cnt_q} + 17'd1) >= 17'(WDOG_LIMIT)) begin
        wdog_err_q <= 1'b1;
      end
    end else begin
      wdog_cnt_q <= 16'd0;
    end
  end

  assign ic.ic_wdog_err = wdog_err_q;
`else
  // Legal WDOG_LIMIT is never below 1, so this is a constant 0
  assign ic.ic_wdog_err = (WDOG_LIMIT < 1);
`endif

endmodule

// File: doc/mcpu_core_issue_ctl.md
MCPU_CORE_ISSUE_CTL -- requirements
Module: MCPU_CORE_issue_ctl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles issue is blocked after a flush (legal 1..15).
REQ-002 Parameter WDOG_LIMIT, default 1023, stall-cycle count at which the watchdog fires (legal 1..65535).
REQ-003 clkrst_core_clk  in  1  core clock; all state on rising edge.
REQ-004 clkrst_core_rst  in  1  asynchronous, active-high reset.
REQ-005 sb2d_reg_scoreboard  in  32  pending-write bit per GPR, from the scoreboard.
REQ-006 sb2d_pred_scoreboard  in  3  pending-write bit per predicate, from the scoreboard.
REQ-007 d2ic_valid  in  1  decode holds a packet ready to issue.
REQ-008 d2ic_rs_mask  in  32  OR of one-hot source GPRs read by all lanes of the packet.
REQ-009 d2ic_rd_mask  in  32  OR of one-hot destination GPRs written by the packet.
REQ-010 d2ic_pred_mask  in  3  predicates read or written by the packet.
REQ-011 d2ic_flush  in  1  pipeline flush request (branch/exception), single-cycle pulse.
REQ-012 pc2ic_ready  in  1  downstream stage can accept a packet this cycle.
REQ-013 ic_cnt_clr  in  1  synchronous clear of the stall counter.
REQ-014 d2pc_progress  out  1  packet issues this cycle; drives the scoreboard's progress input.
REQ-015 ic2d_stall  out  1  decode must hold its packet.
REQ-016 ic_state  out  2  current FSM state encoding.
REQ-017 ic_stall_cnt  out  16  saturating count of hazard-stall cycles.
REQ-018 ic_wdog_err  out  1  sticky watchdog error flag.

Function
REQ-019 hazard = |(d2ic_rs_mask & sb2d_reg_scoreboard) | |(d2ic_rd_mask & sb2d_reg_scoreboard) | |(d2ic_pred_mask & sb2d_pred_scoreboard); bit 0 of both GPR masks is ignored (r0).
REQ-020 d2pc_progress = d2ic_valid & ~hazard & pc2ic_ready & ~d2ic_flush & (ic_state != FLUSH), combinational, zero-latency.
REQ-021 ic2d_stall = d2ic_valid & ~d2pc_progress.
REQ-022 FSM states, encoded IDLE=0, ISSUE=1, STALL=2, FLUSH=3; ic_state is the registered state.
REQ-023 Priority of next-state: d2ic_flush -> FLUSH (count loaded FLUSH_CYCLES-1), from any state including FLUSH (restart).
REQ-024 FLUSH: count decrements each cycle; at count 0 next state is IDLE; d2pc_progress held 0 throughout.
REQ-025 Otherwise: d2pc_progress=1 -> ISSUE; d2ic_valid & ~d2pc_progress -> STALL; ~d2ic_valid -> IDLE.
REQ-026 Back-to-back dependent packets: a hazard set by a packet issued in cycle N is visible in sb2d in cycle N+1; the block adds no extra delay.
REQ-027 ic_stall_cnt increments by 1 in each cycle where d2ic_valid & hazard & ~d2ic_flush & state!=FLUSH; saturates at 16'hFFFF; stalls due only to ~pc2ic_ready are not counted.
REQ-028 ic_cnt_clr sets ic_stall_cnt to 0 next cycle; clear wins over simultaneous increment.

Reset
REQ-029 While clkrst_core_rst is high: ic_state=IDLE, flush count=0, ic_stall_cnt=0, watchdog count=0, ic_wdog_err=0.
REQ-030 Outputs d2pc_progress and ic2d_stall follow REQ-020/021 from inputs during reset with state IDLE; reset asserted mid-STALL or mid-FLUSH returns to IDLE immediately, asynchronously.

Configuration
REQ-031 Macro MCPU_ISSUE_WATCHDOG_EN: when defined, a 16-bit watchdog counter counts consecutive cycles in STALL, clears on any other state, and sets ic_wdog_err when it reaches WDOG_LIMIT; ic_wdog_err stays 1 until reset.
REQ-032 Without MCPU_ISSUE_WATCHDOG_EN: no watchdog counter is built and ic_wdog_err is tied 0; all other behaviour identical.

Verification
REQ-033 Reset, then valid=1, masks 0, ready=1 -> progress=1 same cycle, state=ISSUE next cycle, stall_cnt=0.
REQ-034 reg_scoreboard=32'h0000_0020, rs_mask=32'h0000_0020, valid=1 for 5 cycles then scoreboard clears -> stall=1 for 5 cycles, stall_cnt=5, progress=1 on 6th cycle.
REQ-035 rs_mask=32'h1 with reg_scoreboard=32'h1 -> no hazard, progress=1 (r0 ignored); pred_mask=3'b100 with pred_scoreboard=3'b100 -> stall.
REQ-036 Flush pulse during STALL with FLUSH_CYCLES=2 -> progress=0 for flush cycle plus 2 FLUSH cycles, then IDLE; second flush in FLUSH restarts count.
REQ-037 With MCPU_ISSUE_WATCHDOG_EN, WDOG_LIMIT=4, permanent hazard -> ic_wdog_err=1 after 4th STALL cycle, remains 1 after hazard clears; without macro -> stays 0.
REQ-038 stall_cnt preloaded to 16'hFFFF by sustained hazard -> holds 16'hFFFF; ic_cnt_clr asserted with hazard -> 0 next cycle.
